// File: rtl/dma_copy_master.sv
// Single-channel word copy engine on a native valid/ready memory bus: one read, then one write per word.
// Optional DMA_TIMEOUT_EN adds a stall watchdog that aborts a request left waiting TIMEOUT_CYCLES cycles.
module dma_copy_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned COUNT_W        = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic [31:0]        src_addr,
    input  logic [31:0]        dst_addr,
    input  logic [COUNT_W-1:0] word_count,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               mem_valid,
    output logic               mem_instr,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    output logic [3:0]         mem_wstrb,
    input  logic               mem_ready,
    input  logic [31:0]        mem_rdata,
    output logic [2:0]         dbg_state
);

    // Bus handshake: a transfer completes on a rising edge where mem_valid && mem_ready.
    // While mem_valid is high and mem_ready low, mem_addr/mem_wdata/mem_wstrb hold steady;
    // mem_ready seen while mem_valid is low has no effect.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        RD_GAP = 3'd2,
        WR_REQ = 3'd3,
        WR_GAP = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]        data_q, data_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

`ifdef DMA_TIMEOUT_EN
    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
                        error_d = 1'b1;
                    end else if (word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RD_REQ;
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        cnt_d   = word_count;
                    end
                end
            end
            RD_REQ: begin
                if (mem_ready) begin
                    data_d  = mem_rdata;
                    state_d = RD_GAP;
                end
            end
            RD_GAP: state_d = WR_REQ;
            WR_REQ: begin
                if (mem_ready) begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    cnt_d   = cnt_q - COUNT_W'(1);
                    state_d = WR_GAP;
                end
            end
            WR_GAP: state_d = (cnt_q != '0) ? RD_REQ : FINISH;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef DMA_TIMEOUT_EN
        // A stalled request overrides the normal next state and abandons the copy.
        wait_d = '0;
        if (((state_q == RD_REQ) || (state_q == WR_REQ)) && !mem_ready) begin
            if (wait_q == WAIT_LAST) begin
                state_d = IDLE;
                error_d = 1'b1;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef DMA_TIMEOUT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef DMA_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    // Bus outputs decode straight from state so they drop the cycle after reset or abort.
    assign mem_valid = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem_instr = 1'b0;
    assign mem_addr  = (state_q == RD_REQ) ? src_q :
                       (state_q == WR_REQ) ? dst_q : 32'd0;
    assign mem_wdata = (state_q == WR_REQ) ? data_q : 32'd0;
    assign mem_wstrb = (state_q == WR_REQ) ? 4'b1111 : 4'b0000;
    assign busy      = (state_q != IDLE) && (state_q != FINISH);
    assign done      = done_q || (state_q == FINISH);
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dma_copy_master.sv
// Directed bench for dma_copy_master: a memory responder with configurable wait states feeds
// read data and checks every write against an expected queue filled when each copy is started.
module tb_dma_copy_master;

  logic        clk_i;
  logic        reset_i;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        error;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [2:0]  dbg_state;

  int tests_run = 0;
  int fails     = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] rd_addr_q[$];

  int wait_cfg    = 0;
  bit noise       = 0;
  int bus_cycles  = 0;
  bit phase_wr    = 0;

  dma_copy_master #(
    .TIMEOUT_CYCLES(8),
    .COUNT_W(16)
  ) dut (
    .CLK(clk_i),
    .RESET(reset_i),
    .start(start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .word_count(word_count),
    .busy(busy),
    .done(done),
    .error(error),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // memory responder: decides mem_ready at each falling edge for the next rising edge
  initial begin
    int          wait_cnt;
    bit          prev_wait;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;
    logic [3:0]  prev_wstrb;
    wait_cnt  = 0;
    prev_wait = 0;
    prev_addr = '0;
    prev_wdata = '0;
    prev_wstrb = '0;
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk_i);
      mem_rdata = 32'hDEAD_BEEF;
      if (mem_valid) begin
        bus_cycles++;
        if (prev_wait) begin
          check("stall_addr_stable", mem_addr, prev_addr);
          check("stall_wdata_stable", mem_wdata, prev_wdata);
          check("stall_wstrb_stable", {28'd0, mem_wstrb}, {28'd0, prev_wstrb});
        end
        if (wait_cnt >= wait_cfg) begin
          mem_ready = 1'b1;
          wait_cnt  = 0;
          check("access_order_wstrb", {28'd0, mem_wstrb}, phase_wr ? 32'hF : 32'h0);
          if (phase_wr) begin
            if (exp_q.size() == 0) begin
              check("unexpected_write", 32'd1, 32'd0);
            end else begin
              check("write_addr", mem_addr, exp_addr_q.pop_front());
              check("write_data", mem_wdata, exp_q.pop_front());
            end
          end else begin
            if (rd_addr_q.size() == 0) begin
              check("unexpected_read", 32'd1, 32'd0);
            end else begin
              check("read_addr", mem_addr, rd_addr_q.pop_front());
            end
            mem_rdata = mem_word(mem_addr);
          end
          phase_wr  = ~phase_wr;
          prev_wait = 0;
        end else begin
          mem_ready  = 1'b0;
          wait_cnt++;
          prev_wait  = 1;
          prev_addr  = mem_addr;
          prev_wdata = mem_wdata;
          prev_wstrb = mem_wstrb;
        end
      end else begin
        mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        wait_cnt  = 0;
        prev_wait = 0;
      end
    end
  end

  // driver: starts a copy at a falling edge and waits (bounded) for done or error
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] c,
                          input bit poke, output int lat);
    for (int i = 0; i < int'(c); i++) begin
      rd_addr_q.push_back(s + 32'(4 * i));
      exp_addr_q.push_back(d + 32'(4 * i));
      exp_q.push_back(mem_word(s + 32'(4 * i)));
    end
    phase_wr   = 0;
    src_addr   = s;
    dst_addr   = d;
    word_count = c;
    start      = 1'b1;
    lat        = 0;
    do begin
      @(negedge clk_i);
      lat++;
      start = 1'b0;
      if (poke && lat == 5) begin
        src_addr   = 32'h0000_0400;
        dst_addr   = 32'h0000_0500;
        word_count = 16'd2;
        start      = 1'b1;
      end
      if (lat == 1) check("busy_after_start", {31'd0, busy}, 32'd1);
    end while (!done && !error && lat < 400);
    start = 1'b0;
  endtask

  task automatic flush_queues();
    exp_q.delete();
    exp_addr_q.delete();
    rd_addr_q.delete();
  endtask

  initial begin
    int lat;
    int b0;
    bit stayed;
    reset_i    = 1'b1;
    start      = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    word_count = '0;

    // reset state
    repeat (3) @(negedge clk_i);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_mem_instr", {31'd0, mem_instr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // zero-wait copy of 3 words
    wait_cfg = 0;
    run_copy(32'h100, 32'h200, 16'd3, 0, lat);
    check("copy0_done", {31'd0, done}, 32'd1);
    check("copy0_no_error", {31'd0, error}, 32'd0);
    check("copy0_latency_12_13", {31'd0, (lat >= 12 && lat <= 13)}, 32'd1);
    check("copy0_busy_low_at_done", {31'd0, busy}, 32'd0);
    check("copy0_all_written", 32'(exp_q.size()), 32'd0);
    @(negedge clk_i);
    check("copy0_done_pulse_ends", {31'd0, done}, 32'd0);

    // same copy with 2 wait states per access and ready noise between requests
    wait_cfg = 2;
    noise    = 1;
    run_copy(32'h100, 32'h200, 16'd3, 0, lat);
    check("copy2w_done", {31'd0, done}, 32'd1);
    check("copy2w_all_written", 32'(exp_q.size()), 32'd0);
    noise = 0;
    @(negedge clk_i);

    // wrapping addresses, plus a start pulse while busy that must be dropped
    wait_cfg = 1;
    run_copy(32'hFFFF_FFF8, 32'hFFFF_FFFC, 16'd3, 1, lat);
    check("wrap_done", {31'd0, done}, 32'd1);
    check("wrap_no_error", {31'd0, error}, 32'd0);
    check("wrap_all_written", 32'(exp_q.size()), 32'd0);
    b0 = bus_cycles;
    repeat (8) @(negedge clk_i);
    check("busy_start_ignored", 32'(bus_cycles), 32'(b0));
    check("busy_start_idle", {31'd0, busy}, 32'd0);

    // misaligned source, then misaligned destination
    b0 = bus_cycles;
    src_addr = 32'h102; dst_addr = 32'h200; word_count = 16'd3; start = 1'b1;
    @(negedge clk_i);
    start = 1'b0;
    check("misalign_src_error", {31'd0, error}, 32'd1);
    check("misalign_src_no_done", {31'd0, done}, 32'd0);
    check("misalign_src_not_busy", {31'd0, busy}, 32'd0);
    @(negedge clk_i);
    check("misalign_src_pulse_ends", {31'd0, error}, 32'd0);
    src_addr = 32'h100; dst_addr = 32'h201; start = 1'b1;
    @(negedge clk_i);
    start = 1'b0;
    check("misalign_dst_error", {31'd0, error}, 32'd1);
    repeat (4) @(negedge clk_i);
    check("misalign_no_bus", 32'(bus_cycles), 32'(b0));

    // zero word count
    src_addr = 32'h100; dst_addr = 32'h200; word_count = 16'd0; start = 1'b1;
    @(negedge clk_i);
    start = 1'b0;
    check("count0_done", {31'd0, done}, 32'd1);
    check("count0_no_error", {31'd0, error}, 32'd0);
    @(negedge clk_i);
    check("count0_pulse_ends", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk_i);
    check("count0_no_bus", 32'(bus_cycles), 32'(b0));

    // reset while the second word's write request is pending
    wait_cfg = 3;
    for (int i = 0; i < 3; i++) begin
      rd_addr_q.push_back(32'h100 + 32'(4 * i));
      exp_addr_q.push_back(32'h200 + 32'(4 * i));
      exp_q.push_back(mem_word(32'h100 + 32'(4 * i)));
    end
    phase_wr = 0;
    src_addr = 32'h100; dst_addr = 32'h200; word_count = 16'd3; start = 1'b1;
    @(negedge clk_i);
    start = 1'b0;
    lat = 0;
    while (!(mem_valid && mem_wstrb == 4'hF && mem_addr == 32'h204) && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    check("rst_mid_reached_wr2", {31'd0, (lat < 200)}, 32'd1);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    check("rst_mid_valid_low", {31'd0, mem_valid}, 32'd0);
    check("rst_mid_busy_low", {31'd0, busy}, 32'd0);
    check("rst_mid_words_left", 32'(exp_q.size()), 32'd2);
    flush_queues();
    b0 = bus_cycles;
    repeat (10) @(negedge clk_i);
    check("rst_mid_no_more_bus", 32'(bus_cycles), 32'(b0));

    // responder that never readies
    wait_cfg = 100000;
    run_copy(32'h100, 32'h200, 16'd3, 0, lat);
`ifdef DMA_TIMEOUT_EN
    check("timeout_error", {31'd0, error}, 32'd1);
    check("timeout_latency", 32'(lat), 32'd9);
    check("timeout_valid_dropped", {31'd0, mem_valid}, 32'd0);
    check("timeout_busy_low", {31'd0, busy}, 32'd0);
`else
    stayed = 1;
    check("no_timeout_no_error", {31'd0, error}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (!mem_valid || error) stayed = 0;
    end
    check("no_timeout_valid_held", {31'd0, stayed}, 32'd1);
    check("no_timeout_busy", {31'd0, busy}, 32'd1);
`endif
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    flush_queues();
    wait_cfg = 0;
    check("final_idle_valid", {31'd0, mem_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
